// File: rtl/pos_decoder_pkg.sv
// pos_decoder_pkg: shared types and the position decode function.
// POS_DECODER_THERMO_EN selects thermometer decode instead of one-hot.
package pos_decoder_pkg;
    typedef logic [2:0] pos_t;
    typedef struct packed {
        logic run;
        pos_t pos;
    } entry_t;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    function automatic logic [7:0] decode(entry_t e);
`ifdef POS_DECODER_THERMO_EN
        return e.run ? 8'hFF >> (3'd7 - e.pos) : 8'h00;
`else
        return e.run ? 8'd1 << e.pos : 8'h00;
`endif
    endfunction
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: active-low seven-segment decoder {g,f,e,d,c,b,a}; non-decimal codes blank.
module bcd7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/pos_fifo.sv
// pos_fifo: synchronous FIFO of entry_t with full/empty flags.
module pos_fifo
    import pos_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t din_i,
    input  logic   pop_i,
    output entry_t dout_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(do_push);
            rd_q <= rd_q + (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/pos_decoder.sv
// pos_decoder: buffers {run,pos} codes and replays each on the LEDs for a dwell slot plus a gap.
// Define POS_DECODER_THERMO_EN for thermometer patterns instead of one-hot.
module pos_decoder
    import pos_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_pos,
    input  logic               in_run,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         led,
    output logic               busy,
    output logic [6:0]         HEX0
);
    state_t state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [7:0] led_q, led_d;
    pos_t pos_q, pos_d;
    entry_t head;
    logic full, empty, pop;
    assign pop = en && state_q == IDLE && !empty;
    assign in_ready = !full;
    pos_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (in_valid),
        .din_i  ('{run: in_run, pos: in_pos}),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            pos_q   <= pos_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        pos_d   = pos_q;
        if (en) begin
            case (state_q)
                IDLE: if (!empty) begin
                    state_d = SHOW;
                    pos_d   = head.run ? head.pos : '0;
                    led_d   = decode(head);
                    cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                end
                SHOW: if (cnt_q == '0) begin
                    state_d = GAP;
                    led_d   = '0;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // Disabling blanks the LEDs without disturbing the stored pattern.
    always_comb begin
        led  = en ? led_q : 8'h00;
        busy = state_q != IDLE || !empty;
    end
    bcd7seg u_seg (
        .bcd({1'b0, pos_q}),
        .seg(HEX0)
    );
endmodule
